dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder for the core's dcache load/store port. Serves a tightly-coupled word RAM
//  and a small MMIO window:
//   - 64-bit cycle counter
//   - tohost register that ends simulation
//  Performs byte-lane store merging, load alignment, sign/zero extension and fault
//  detection. Fixed 1-cycle load latency; the core does not stall on it.
// PARAMETERS
//  DATA_BASE  32'h10010000  byte base address of RAM window (4-byte aligned)
//  ADDR_W     12            RAM depth = 2**ADDR_W words (16 KiB default)
//  MMIO_BASE  32'hFFFF0000  base of MMIO window (3 word registers)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  dcache_r_ena    in   1   load request this cycle
//  dcache_w_ena    in   1   store request this cycle
//  dcache_ext      in   1   loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
//  dcache_width    in   2   00 byte, 01 half, 10 word, 11 illegal
//  dcache_addr     in   32  byte address
//  dcache_data_in  in   32  store data, LSB-aligned
//  dcache_valid    out  1   1-cycle pulse, cycle after any request (load or store)
//  dcache_data_out out  32  formatted load data
//  fault           out  1   1-cycle pulse with dcache_valid when request faulted
//  fault_addr      out  32  address of most recent faulting request
//  tohost_valid    out  1   sticky, set by first store to tohost
//  tohost_data     out  32  value of that store
// BEHAVIOUR
//  Reset: all outputs 0; counter 0; counter shadow 0; RAM contents not reset.
//  Request = r_ena | w_ena, sampled at the rising edge.
//  Response timing: dcache_valid, fault and the load data appear in the next cycle.
//  dcache_data_out: holds the last load result until the next load completes.
//    Stores do not disturb it, even stores to the same address.
//  Decode, word address wa = addr[31:2]:
//    RAM   : DATA_BASE <= addr < DATA_BASE + 4*2**ADDR_W
//    MMIO  : MMIO_BASE + {0, 4, 8} = CNT_LO, CNT_HI, TOHOST
//    other : unmapped
//  Fault conditions; on a fault there is no RAM/MMIO side effect and the load returns 0:
//    - r_ena & w_ena both set
//    - width 11
//    - misaligned access: half with addr[0]=1; word with addr[1:0]!=0
//    - unmapped address
//    - MMIO access with width != word
//  Store lanes, byte offset o = addr[1:0]:
//    - byte: lane o <= data_in[7:0]
//    - half: lanes o, o+1 <= data_in[15:0]
//    - word: all 4 lanes
//    - untouched lanes are preserved
//  Load format:
//    - select byte/half at offset o of the read word
//    - extend to 32 bits: ext=0 sign-extends, ext=1 zero-extends
//  RAM is single-port synchronous.
//    - Read and write occur only on request cycles, so back-to-back store/load works.
//    - A store at cycle t followed by a load of the same word at t+1 returns the new data.
//  Cycle counter: 64-bit, increments every cycle out of reset, wraps 2^64-1 -> 0.
//    - Loading CNT_LO returns counter[31:0] as of the request edge.
//    - The same load copies counter[63:32] into the shadow.
//    - Loading CNT_HI returns the shadow, not the live value, so an LO-then-HI pair
//      is coherent across carry.
//    - Stores to CNT_LO/CNT_HI are ignored, no fault.
//  TOHOST: the first word store sets tohost_valid=1 and tohost_data=data_in.
//    - Later stores are ignored.
//    - Loads return tohost_data.
//  fault_addr updates only on faulting requests.
//  Reset mid-operation: an in-flight response is discarded.
//    - dcache_valid is 0 in the cycle after rst_n deasserts.
// TESTING
//  1 sw 0x8899AABB @DATA_BASE; next cycle lb @DATA_BASE+3, ext=0
//    -> data_out 0xFFFFFF88, valid pulse, fault 0.
//  2 sb 0x11 @DATA_BASE+1 over 0x8899AABB, then lhu @DATA_BASE
//    -> 0x000011BB; lw -> 0x889911BB.
//  3 lh @DATA_BASE+1 -> fault=1, fault_addr=DATA_BASE+1, data_out 0, RAM unchanged;
//    r_ena & w_ena together -> fault, no write.
//  4 Force counter to 0x00000000_FFFFFFFE; lw CNT_LO -> 0xFFFFFFFF; wait 3 cycles;
//    lw CNT_HI -> 0x00000000 (shadow), not 1.
//  5 sw 0x1 to TOHOST -> tohost_valid=1, tohost_data=1; sw 0x2 -> unchanged;
//    sb to TOHOST -> fault.
//  6 Store at t, rst_n low at t+1 for 2 cycles -> all outputs 0, no valid pulse after
//    release; lw @DATA_BASE+4*(2**ADDR_W) -> fault.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Responder for the core's dcache load/store port. Serves a tightly-coupled
//   word RAM plus a small MMIO window (64-bit cycle counter, tohost register).
//   Handles byte-lane store merging, load alignment, sign/zero extension and
//   fault detection. Every request gets a one-cycle-later response pulse.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   dcache_r_ena     load request
//   dcache_w_ena     store request
//   dcache_ext       loads: 1 zero-extend, 0 sign-extend
//   dcache_width     00 byte, 01 half, 10 word, 11 illegal
//   dcache_addr      byte address
//   dcache_data_in   store data, LSB-aligned
//   dcache_valid     response pulse, cycle after any request
//   dcache_data_out  formatted load data, held until the next load completes
//   fault            pulse alongside dcache_valid when the request faulted
//   fault_addr       address of the most recent faulting request
//   tohost_valid     sticky, set by the first word store to tohost
//   tohost_data      value of that store
module dmem_responder #(
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  // Value the cycle counter takes in reset (0 in normal use).
  parameter logic [63:0] CNT_INIT  = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dcache_r_ena,
  input  logic        dcache_w_ena,
  input  logic        dcache_ext,
  input  logic [1:0]  dcache_width,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_data_in,
  output logic        dcache_valid,
  output logic [31:0] dcache_data_out,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int          DEPTH   = 1 << ADDR_W;
  // One past the last RAM byte, kept at 33 bits so a window ending at 4 GiB
  // does not wrap.
  localparam logic [32:0] RAM_END = {1'b0, DATA_BASE} + (33'd4 << ADDR_W);

  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  width,
                                           input logic [1:0]  off,
                                           input logic        ext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (width)
      2'b00:   return {{24{b[7] & ~ext}}, b};
      2'b01:   return {{16{h[15] & ~ext}}, h};
      default: return word;
    endcase
  endfunction

  logic [31:0] mem [DEPTH];

  logic              req, both, fault_c, ok;
  logic              in_ram, is_mmio, sel_lo, sel_hi, sel_th;
  logic              misaligned, mmio_bad;
  logic [29:0]       mmio_wa;
  logic [ADDR_W-1:0] ram_idx;
  logic [3:0]        be;
  logic [31:0]       wdata;

  logic [63:0] cnt;
  logic [31:0] shadow;
  logic [31:0] held_q, data_out_c;

  logic        vld_p1, fault_p1, load_p1, src_ram_p1, ext_p1;
  logic [1:0]  width_p1, off_p1;
  logic [31:0] ram_q_p1, mmio_q_p1;

  // ---- stage p0: request decode and fault classification ----
  always_comb begin
    req        = dcache_r_ena | dcache_w_ena;
    both       = dcache_r_ena & dcache_w_ena;
    in_ram     = ({1'b0, dcache_addr} >= {1'b0, DATA_BASE}) &&
                 ({1'b0, dcache_addr} <  RAM_END);
    ram_idx    = ADDR_W'((dcache_addr - DATA_BASE) >> 2);
    // Word distance from the MMIO base; wraps huge for addresses below it.
    mmio_wa    = dcache_addr[31:2] - MMIO_BASE[31:2];
    is_mmio    = mmio_wa < 30'd3;
    sel_lo     = is_mmio && (mmio_wa[1:0] == 2'd0);
    sel_hi     = is_mmio && (mmio_wa[1:0] == 2'd1);
    sel_th     = is_mmio && (mmio_wa[1:0] == 2'd2);
    misaligned = ((dcache_width == 2'b01) && dcache_addr[0]) ||
                 ((dcache_width == 2'b10) && (dcache_addr[1:0] != 2'b00));
    mmio_bad   = is_mmio && (dcache_width != 2'b10);
    fault_c    = req && (both || (dcache_width == 2'b11) || misaligned ||
                         (!in_ram && !is_mmio) || mmio_bad);
    ok         = req && !fault_c;
  end

  // Store data is replicated across lanes so each enabled lane picks up the
  // right bytes regardless of offset.
  always_comb begin
    be    = 4'b0000;
    wdata = dcache_data_in;
    case (dcache_width)
      2'b00: begin
        be    = 4'b0001 << dcache_addr[1:0];
        wdata = {4{dcache_data_in[7:0]}};
      end
      2'b01: begin
        be    = dcache_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{dcache_data_in[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // ---- stage p0 -> p1: RAM access and response capture ----
  always_ff @(posedge clk) begin
    if (ok && dcache_w_ena && in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (ok && dcache_r_ena && in_ram) ram_q_p1 <= mem[ram_idx];
  end

  always_ff @(posedge clk) begin
    width_p1   <= dcache_width;
    ext_p1     <= dcache_ext;
    off_p1     <= dcache_addr[1:0];
    src_ram_p1 <= in_ram;
    // CNT_LO returns the counter as sampled at the request edge; CNT_HI
    // returns the shadow captured by the most recent CNT_LO load.
    mmio_q_p1  <= sel_lo ? cnt[31:0] : (sel_hi ? shadow : tohost_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      fault_p1     <= 1'b0;
      load_p1      <= 1'b0;
      held_q       <= '0;
      cnt          <= CNT_INIT;
      shadow       <= '0;
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
      fault_addr   <= '0;
    end else begin
      vld_p1   <= req;
      fault_p1 <= fault_c;
      load_p1  <= dcache_r_ena;
      held_q   <= data_out_c;
      cnt      <= cnt + 64'd1;
      if (ok && dcache_r_ena && sel_lo) shadow <= cnt[63:32];
      if (ok && dcache_w_ena && sel_th && !tohost_valid) begin
        tohost_valid <= 1'b1;
        tohost_data  <= dcache_data_in;
      end
      if (fault_c) fault_addr <= dcache_addr;
    end
  end

  // ---- stage p1: load formatting and hold ----
  always_comb begin
    data_out_c = held_q;
    if (load_p1) begin
      data_out_c = fault_p1 ? 32'd0
                 : fmt_load(src_ram_p1 ? ram_q_p1 : mmio_q_p1,
                            width_p1, off_p1, ext_p1);
    end
  end

  assign dcache_valid    = vld_p1;
  assign fault           = fault_p1;
  assign dcache_data_out = data_out_c;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Drives directed and random load/store traffic into dmem_responder and
//   compares every response against a word-level reference model.
module tb_dmem_responder;

  localparam logic [31:0] DB    = 32'h1001_0000;
  localparam int          AW    = 12;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] MB    = 32'hFFFF_0000;
  localparam logic [63:0] CI    = 64'h0000_0000_FFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dcache_r_ena, dcache_w_ena, dcache_ext;
  logic [1:0]  dcache_width;
  logic [31:0] dcache_addr, dcache_data_in;
  logic        dcache_valid, fault, tohost_valid;
  logic [31:0] dcache_data_out, fault_addr, tohost_data;

  dmem_responder #(
    .DATA_BASE(DB), .ADDR_W(AW), .MMIO_BASE(MB), .CNT_INIT(CI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dcache_r_ena(dcache_r_ena), .dcache_w_ena(dcache_w_ena),
    .dcache_ext(dcache_ext), .dcache_width(dcache_width),
    .dcache_addr(dcache_addr), .dcache_data_in(dcache_data_in),
    .dcache_valid(dcache_valid), .dcache_data_out(dcache_data_out),
    .fault(fault), .fault_addr(fault_addr),
    .tohost_valid(tohost_valid), .tohost_data(tohost_data)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset released: counter at an edge = CI + k.
  logic [63:0] k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 64'd0;
    else        k <= k + 64'd1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_shadow, m_th_d, m_dout, m_faddr;
  logic        m_th_v;

  task automatic model_reset();
    m_shadow = '0; m_th_d = '0; m_th_v = 1'b0; m_dout = '0; m_faddr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  {31'd0, dcache_valid}, 32'd0);
    chk({tag, "_fault"},  {31'd0, fault},        32'd0);
    chk({tag, "_dout"},   dcache_data_out,       32'd0);
    chk({tag, "_faddr"},  fault_addr,            32'd0);
    chk({tag, "_thv"},    {31'd0, tohost_valid}, 32'd0);
    chk({tag, "_thd"},    tohost_data,           32'd0);
  endtask

  task automatic idle();
    dcache_r_ena = 1'b0; dcache_w_ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_valid", {31'd0, dcache_valid}, 32'd0);
    chk("idle_fault", {31'd0, fault}, 32'd0);
    chk("idle_hold",  dcache_data_out, m_dout);
  endtask

  // Issue one request (called at a falling edge), update the model, and
  // check the response at the next falling edge. With rst_mid set, reset
  // is asserted right after the request edge and nothing is checked.
  task automatic do_req(input logic r, input logic w, input logic e,
                        input logic [1:0] wd, input logic [31:0] a,
                        input logic [31:0] d, input bit rst_mid = 1'b0);
    logic [63:0] c, v64, mask;
    logic [31:0] ma, word;
    longint unsigned ad;
    bit ram, mm, f;
    int o, nb, idx;
    c   = CI + k;
    ad  = 64'(a);
    ram = (ad >= 64'(DB)) && (ad < 64'(DB) + 64'(4 * DEPTH));
    ma  = (a - MB) >> 2;
    mm  = ma < 32'd3;
    o   = int'(a % 4);
    nb  = 1 << wd;
    idx = int'((a - DB) / 4);
    f   = (r && w) || (wd == 2'b11) || (wd == 2'b01 && (a % 2) != 0) ||
          (wd == 2'b10 && o != 0) || (!ram && !mm) || (mm && wd != 2'b10);
    if (f) begin
      m_faddr = a;
      if (r) m_dout = 32'd0;
    end else if (w) begin
      if (ram) begin
        word = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
        for (int b = 0; b < nb; b++)
          word = (word & ~(32'hFF << (8 * (o + b)))) |
                 (((d >> (8 * b)) & 32'hFF) << (8 * (o + b)));
        m_mem[idx] = word;
      end else if (ma == 32'd2 && !m_th_v) begin
        m_th_v = 1'b1; m_th_d = d;
      end
    end else begin
      if (ram)              word = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
      else if (ma == 32'd0) word = c[31:0];
      else if (ma == 32'd1) word = m_shadow;
      else                  word = m_th_d;
      if (mm && ma == 32'd0) m_shadow = c[63:32];
      v64 = {32'd0, word} >> (8 * o);
      if (nb < 4) begin
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v64  = v64 & mask;
        if (!e && v64[8*nb-1]) v64 = v64 | ~mask;
      end
      m_dout = v64[31:0];
    end
    dcache_r_ena = r; dcache_w_ena = w; dcache_ext = e;
    dcache_width = wd; dcache_addr = a; dcache_data_in = d;
    @(posedge clk);
    #1;
    dcache_r_ena = 1'b0; dcache_w_ena = 1'b0;
    if (rst_mid) begin
      rst_n = 1'b0;
      return;
    end
    @(negedge clk);
    chk("valid",  {31'd0, dcache_valid}, 32'd1);
    chk("fault",  {31'd0, fault}, {31'd0, f});
    chk("dout",   dcache_data_out, m_dout);
    chk("faddr",  fault_addr, m_faddr);
    chk("th_v",   {31'd0, tohost_valid}, {31'd0, m_th_v});
    chk("th_d",   tohost_data, m_th_d);
  endtask

  task automatic lw(input logic [31:0] a);
    do_req(1'b1, 1'b0, 1'b0, 2'b10, a, 32'd0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    do_req(1'b0, 1'b1, 1'b0, 2'b10, a, d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  wd;
    int          sel;
    rst_n = 1'b0;
    dcache_r_ena = 1'b0; dcache_w_ena = 1'b0; dcache_ext = 1'b0;
    dcache_width = 2'b00; dcache_addr = '0; dcache_data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle();

    // Counter carry: LO read at FFFFFFFF, HI read later returns the shadow.
    for (int i = 0; i < 64 && k != 64'd15; i++) idle();
    lw(MB);
    chk("t4_lo", dcache_data_out, 32'hFFFF_FFFF);
    repeat (3) idle();
    lw(MB + 4);
    chk("t4_hi_shadow", dcache_data_out, 32'h0000_0000);
    lw(MB);
    lw(MB + 4);
    chk("t4_hi_after", dcache_data_out, 32'h0000_0001);
    do_req(1'b0, 1'b1, 1'b0, 2'b10, MB, 32'h1234_5678);

    // Store then immediate sign-extended byte load.
    sw(DB, 32'h8899_AABB);
    do_req(1'b1, 1'b0, 1'b0, 2'b00, DB + 3, 32'd0);
    chk("t1_lb", dcache_data_out, 32'hFFFF_FF88);

    // Byte merge, zero-extended half, full word.
    do_req(1'b0, 1'b1, 1'b0, 2'b00, DB + 1, 32'h0000_0011);
    do_req(1'b1, 1'b0, 1'b1, 2'b01, DB, 32'd0);
    chk("t2_lhu", dcache_data_out, 32'h0000_11BB);
    lw(DB);
    chk("t2_lw", dcache_data_out, 32'h8899_11BB);

    // Misaligned half, simultaneous read/write, RAM untouched.
    do_req(1'b1, 1'b0, 1'b0, 2'b01, DB + 1, 32'd0);
    chk("t3_faddr", fault_addr, DB + 1);
    chk("t3_dout0", dcache_data_out, 32'd0);
    do_req(1'b1, 1'b1, 1'b0, 2'b10, DB, 32'hDEAD_BEEF);
    sw(DB + 4, 32'hFFFF_FFFF);
    do_req(1'b0, 1'b1, 1'b0, 2'b00, DB + 4, 32'h0000_0042);
    lw(DB);
    chk("t3_ram_kept", dcache_data_out, 32'h8899_11BB);

    // tohost: first word store sticks, later ones ignored, byte store faults.
    sw(MB + 8, 32'h0000_0001);
    chk("t5_thv", {31'd0, tohost_valid}, 32'd1);
    sw(MB + 8, 32'h0000_0002);
    chk("t5_thd", tohost_data, 32'h0000_0001);
    do_req(1'b0, 1'b1, 1'b0, 2'b00, MB + 8, 32'h0000_0003);
    lw(MB + 8);

    // Random traffic over an initialised region, MMIO, RAM edges, unmapped.
    for (int i = 0; i < 16; i++) sw(DB + 4 * i, $urandom);
    sw(DB + 4 * (DEPTH - 2), $urandom);
    sw(DB + 4 * (DEPTH - 1), $urandom);
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = DB + $urandom_range(0, 63);
      else if (sel == 7) a = MB + $urandom_range(0, 15);
      else if (sel == 8) a = DB + 4 * DEPTH - 8 + $urandom_range(0, 15);
      else               a = {4'h4, 28'($urandom)};
      sel = $urandom_range(0, 9);
      wd  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 9) < 6) begin
        if (wd == 2'b01) a[0] = 1'b0;
        if (wd == 2'b10) a[1:0] = 2'b00;
      end
      d   = $urandom;
      sel = $urandom_range(0, 19);
      if (sel < 9)       do_req(1'b1, 1'b0, 1'($urandom), wd, a, d);
      else if (sel < 18) do_req(1'b0, 1'b1, 1'($urandom), wd, a, d);
      else if (sel < 19) do_req(1'b1, 1'b1, 1'b0, wd, a, d);
      else               idle();
    end
    lw(DB + 4 * (DEPTH - 1));
    chk("last_word_ok", {31'd0, fault}, 32'd0);

    // Reset right after a store: response dropped, store kept.
    do_req(1'b0, 1'b1, 1'b0, 2'b10, DB + 8, 32'hCAFE_F00D, 1'b1);
    #1;
    model_reset();
    chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("midrst2");
    rst_n = 1'b1;
    idle();
    lw(DB + 4 * DEPTH);
    chk("t6_end_fault", {31'd0, fault}, 32'd1);
    lw(DB + 8);
    chk("t6_store_kept", dcache_data_out, 32'hCAFE_F00D);
    lw(MB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
